load_data_unpack: RTL and testbench

//   Load-side counterpart of the store-lane replicator in the memory stage.
//   It queues load metadata (mem_op, address offset, destination tag) at

---
 rtl/load_data_unpack_if.sv | 40 ++++
 rtl/load_data_unpack.sv | 152 +++++++++++++++
 tb/tb_load_data_unpack.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_data_unpack_if.sv
// Load-unpack bus interface.
// Groups the three handshake channels of the load unpacker:
//   req_*   : load issue (op, address offset, destination tag)
//   mem_*   : 64-bit read beats from data memory
//   resp_*  : extracted, extended result toward writeback
//   spurious_err : sticky flag, beat seen with no outstanding load
// req_op encoding: 0 NO, 1 B, 2 H, 3 W, 4 D, 5 UB, 6 UH, 7 UW.
// slave  = unpacker side, master = issue/memory/writeback side.
interface load_data_unpack_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [2:0]       req_off;
    logic [TAG_W-1:0] req_tag;

    logic             mem_rvalid;
    logic             mem_rready;
    logic [63:0]      mem_rdata;

    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_misalign;
    logic             spurious_err;

    modport slave (
        input  req_valid, req_op, req_off, req_tag, mem_rvalid, mem_rdata, resp_ready,
        output req_ready, mem_rready, resp_valid, resp_data, resp_tag, resp_misalign,
               spurious_err
    );

    modport master (
        output req_valid, req_op, req_off, req_tag, mem_rvalid, mem_rdata, resp_ready,
        input  req_ready, mem_rready, resp_valid, resp_data, resp_tag, resp_misalign,
               spurious_err
    );
endinterface

// File: rtl/load_data_unpack.sv
// Load data unpacker.
// Queues load metadata at issue time, then consumes 64-bit read beats in order,
// selects the addressed byte/half/word/double, sign- or zero-extends it and
// presents it on a registered valid/ready response port.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : load_data_unpack_if.slave (req, mem read beat, resp, spurious_err)
module load_data_unpack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input logic               clk,
    input logic               rstn,
    load_data_unpack_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        MemNo = 3'd0,
        MemB  = 3'd1,
        MemH  = 3'd2,
        MemW  = 3'd3,
        MemD  = 3'd4,
        MemUb = 3'd5,
        MemUh = 3'd6,
        MemUw = 3'd7
    } mem_op_e;

    // Metadata storage: datapath only, no reset needed.
    mem_op_e          op_q  [DEPTH];
    logic [2:0]       off_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             resp_valid_q;
    logic [63:0]      resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic             resp_mis_q;
    logic             spurious_q;

    mem_op_e    head_op;
    logic [2:0] head_off;
    logic       not_empty, out_free, req_ready, mem_rready;
    logic       push, beat, pop;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] sel_w;
    logic [63:0] ext_data;
    logic        ext_mis;

    assign head_op   = op_q[rd_ptr_q];
    assign head_off  = off_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign out_free  = !resp_valid_q || bus.resp_ready;

    // Registered count only: a same-cycle pop never frees a slot for a push.
    assign req_ready  = (count_q < CNT_W'(DEPTH));
    assign push       = bus.req_valid && req_ready;
    assign mem_rready = not_empty && out_free && (head_op != MemNo);
    assign beat       = bus.mem_rvalid && mem_rready;
    // MEM_NO entries retire without consuming a beat.
    assign pop        = beat || (not_empty && out_free && (head_op == MemNo));

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Lane select uses the truncated offset even when misaligned.
    always_comb begin
        sel_b    = bus.mem_rdata[{head_off, 3'b000} +: 8];
        sel_h    = bus.mem_rdata[{head_off[2:1], 4'b0000} +: 16];
        sel_w    = bus.mem_rdata[{head_off[2], 5'b00000} +: 32];
        ext_data = '0;
        ext_mis  = 1'b0;
        unique case (head_op)
            MemNo: ext_data = '0;
            MemB:  ext_data = {{56{sel_b[7]}}, sel_b};
            MemUb: ext_data = {56'd0, sel_b};
            MemH:  begin
                ext_data = {{48{sel_h[15]}}, sel_h};
                ext_mis  = head_off[0];
            end
            MemUh: begin
                ext_data = {48'd0, sel_h};
                ext_mis  = head_off[0];
            end
            MemW:  begin
                ext_data = {{32{sel_w[31]}}, sel_w};
                ext_mis  = |head_off[1:0];
            end
            MemUw: begin
                ext_data = {32'd0, sel_w};
                ext_mis  = |head_off[1:0];
            end
            MemD:  begin
                ext_data = bus.mem_rdata;
                ext_mis  = |head_off;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_q[wr_ptr_q]  <= mem_op_e'(bus.req_op);
            off_q[wr_ptr_q] <= bus.req_off;
            tag_q[wr_ptr_q] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_mis_q   <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                resp_valid_q <= 1'b1;
                resp_data_q  <= ext_data;
                resp_tag_q   <= tag_q[rd_ptr_q];
                resp_mis_q   <= ext_mis;
            end else if (bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            if (bus.mem_rvalid && !not_empty) spurious_q <= 1'b1;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.mem_rready    = mem_rready;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_tag      = resp_tag_q;
    assign bus.resp_misalign = resp_mis_q;
    assign bus.spurious_err  = spurious_q;
endmodule

// File: tb/tb_load_data_unpack.sv
// Bench for load_data_unpack: table of loads with hand-computed results fed
// through a scoreboard queue, plus sequences for backpressure, spurious beats
// and reset in the middle of traffic.
module tb_load_data_unpack;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 5;
    localparam logic [2:0] OP_NO = 3'd0, OP_B = 3'd1, OP_H = 3'd2, OP_W = 3'd3;
    localparam logic [2:0] OP_D = 3'd4, OP_UB = 3'd5, OP_UH = 3'd6, OP_UW = 3'd7;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    load_data_unpack_if #(.TAG_W(TAG_W)) bus ();

    load_data_unpack #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]       op;
        logic [2:0]       off;
        logic [TAG_W-1:0] tag;
        logic [63:0]      rdata;
        logic [63:0]      exp_data;
        logic             exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             mis;
    } exp_t;

    vec_t vecs [14];
    exp_t sb_q [$];
    int   resp_log [$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard: compare every accepted response against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_resp_tag", 64'(bus.resp_tag), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_data", bus.resp_data, e.data);
                check("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
                check("resp_misalign", 64'(bus.resp_misalign), 64'(e.mis));
                resp_log.push_back(cyc);
            end
        end
    end

    task automatic expect_resp(input logic [63:0] data, input logic [TAG_W-1:0] tag,
                               input logic mis);
        exp_t e;
        e.data = data;
        e.tag  = tag;
        e.mis  = mis;
        sb_q.push_back(e);
    endtask

    // All tasks start and end just after a rising edge.
    task automatic push_req(input logic [2:0] op, input logic [2:0] off,
                            input logic [TAG_W-1:0] tag);
        logic ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_off   = off;
        bus.req_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.req_valid = 1'b0;
        check("req_handshake", 64'(ok), 64'd1);
    endtask

    task automatic send_beat(input logic [63:0] rdata);
        logic ok = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.mem_rvalid = 1'b0;
        check("beat_handshake", 64'(ok), 64'd1);
    endtask

    task automatic do_vec(input vec_t v);
        expect_resp(v.exp_data, v.tag, v.exp_mis);
        push_req(v.op, v.off, v.tag);
        if (v.op != OP_NO) begin
            send_beat(v.rdata);
            @(negedge clk);
            check("latency_1cycle", 64'(bus.resp_valid), 64'd1);
            @(posedge clk);
            #1;
        end else begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{OP_B,  3'd3, 5'd1,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[1]  = '{OP_UB, 3'd3, 5'd2,  64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 1'b0};
        vecs[2]  = '{OP_H,  3'd6, 5'd3,  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        vecs[3]  = '{OP_UW, 3'd4, 5'd4,  64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 1'b0};
        vecs[4]  = '{OP_D,  3'd0, 5'd5,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[5]  = '{OP_H,  3'd1, 5'd6,  64'h0000_0000_00AA_F00D, 64'hFFFF_FFFF_FFFF_F00D, 1'b1};
        vecs[6]  = '{OP_W,  3'd2, 5'd7,  64'h1111_2222_7654_3210, 64'h0000_0000_7654_3210, 1'b1};
        vecs[7]  = '{OP_D,  3'd4, 5'd8,  64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 1'b1};
        vecs[8]  = '{OP_NO, 3'd5, 5'd9,  64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[9]  = '{OP_UH, 3'd2, 5'd10, 64'h0000_0000_ABCD_0000, 64'h0000_0000_0000_ABCD, 1'b0};
        vecs[10] = '{OP_W,  3'd4, 5'd11, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b0};
        vecs[11] = '{OP_B,  3'd0, 5'd12, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F, 1'b0};
        vecs[12] = '{OP_UB, 3'd7, 5'd13, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF, 1'b0};
        vecs[13] = '{OP_H,  3'd4, 5'd14, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_8000, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_op     = OP_NO;
        bus.req_off    = 3'd0;
        bus.req_tag    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset state.
        rstn = 1'b0;
        wait_cycles(3);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_mem_rready", 64'(bus.mem_rready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
        check("rst_resp_misalign", 64'(bus.resp_misalign), 64'd0);
        check("rst_spurious_err", 64'(bus.spurious_err), 64'd0);
        @(posedge clk);
        #1;

        // Extraction / extension / misalign table.
        for (int i = 0; i < 14; i++) do_vec(vecs[i]);
        wait_cycles(3);
        check("table_sb_drained", 64'(sb_q.size()), 64'd0);

        // Full FIFO and held response under backpressure.
        bus.resp_ready = 1'b0;
        expect_resp(64'hFFFF_FFFF_8000_0001, 5'd20, 1'b0);
        expect_resp(64'h0000_0000_0000_00AB, 5'd21, 1'b0);
        push_req(OP_W, 3'd0, 5'd20);
        push_req(OP_UB, 3'd5, 5'd21);
        @(negedge clk);
        check("full_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        send_beat(64'h1234_5678_8000_0001);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h0000_AB00_0000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_mem_rready", 64'(bus.mem_rready), 64'd0);
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_hold_data", bus.resp_data, 64'hFFFF_FFFF_8000_0001);
            check("bp_hold_tag", 64'(bus.resp_tag), 64'd20);
        end
        n = resp_log.size();
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rready", 64'(bus.mem_rready), 64'd1);
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        wait_cycles(2);
        check("bp_result_count", 64'(resp_log.size()), 64'(n + 2));
        if (resp_log.size() >= n + 2)
            check("bp_back_to_back", 64'(resp_log[n+1] - resp_log[n]), 64'd1);
        check("bp_sb_drained", 64'(sb_q.size()), 64'd0);

        // Spurious beat with an empty FIFO.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        check("spur_mem_rready", 64'(bus.mem_rready), 64'd0);
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("spur_flag_set", 64'(bus.spurious_err), 64'd1);
        check("spur_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        do_vec('{OP_UB, 3'd3, 5'd25, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 1'b0});
        wait_cycles(2);
        check("spur_flag_sticky", 64'(bus.spurious_err), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("spur_flag_cleared", 64'(bus.spurious_err), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset in the middle of traffic with a held response.
        bus.resp_ready = 1'b0;
        push_req(OP_D, 3'd0, 5'd26);
        push_req(OP_B, 3'd1, 5'd27);
        send_beat(64'h5555_AAAA_5555_AAAA);
        @(negedge clk);
        check("midrst_pre_valid", 64'(bus.resp_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_resp_data", bus.resp_data, 64'd0);
        check("midrst_resp_tag", 64'(bus.resp_tag), 64'd0);
        check("midrst_resp_misalign", 64'(bus.resp_misalign), 64'd0);
        check("midrst_mem_rready", 64'(bus.mem_rready), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("postrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("postrst_mem_rready", 64'(bus.mem_rready), 64'd0);
        check("postrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        // Stale entries would surface here as a wrong tag or extra result.
        do_vec('{OP_UH, 3'd6, 5'd28, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 1'b0});
        wait_cycles(4);
        check("final_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
